// File: rtl/instr_encoder.sv
// instr_encoder: assembles 12-bit baseline MCU instructions and writes them to program memory.
// Optional readback verification of each written word is enabled by defining ENC_VERIFY_EN.
module instr_encoder #(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        op_sel,
    input  logic [4:0]        f,
    input  logic              d,
    input  logic [2:0]        bbb,
    input  logic [7:0]        k,
    input  logic [8:0]        longk,
    output logic              pm_we,
    output logic [ADDR_W-1:0] pm_addr,
    output logic [11:0]       pm_wdata,
    input  logic [11:0]       pm_rdata,
    output logic [ADDR_W:0]   word_count,
    output logic              err_illegal,
    output logic              wrapped,
    output logic              verify_err
);
    localparam logic [1:0] IDLE = 2'd0, ENCODE = 2'd1, WRITE = 2'd2;
`ifdef ENC_VERIFY_EN
    localparam logic [1:0] VERIFY = 2'd3;
`endif
    logic [1:0]  st;
    logic [5:0]  o;
    logic [4:0]  fr;
    logic        dr;
    logic [2:0]  br;
    logic [7:0]  kr;
    logic [8:0]  lr;
    logic [11:0] w;
    logic        ill;
    assign in_ready = st == IDLE;
    // A start pulse during WRITE drops the word combinationally in that same cycle.
    assign pm_we = st == WRITE && !start;
    always_comb begin
        w = 12'h000;
        ill = 1'b0;
        if (o == 6'd1) w = {7'b0000001, fr};
        else if (o == 6'd2) w = 12'h040;
        else if (o == 6'd3) w = {7'b0000011, fr};
        else if (o >= 6'd4 && o <= 6'd17) w = {o - 6'd2, dr, fr};
        else if (o >= 6'd18 && o <= 6'd21) w = {2'b01, 2'(o - 6'd18), br, fr};
        else if (o == 6'd22) w = 12'h002;
        else if (o == 6'd23) w = 12'h003;
        else if (o == 6'd24) w = 12'h004;
        else if (o == 6'd25) begin
            w = {9'b0, fr[2:0]};
            ill = fr[2:0] != 3'd5 && fr[2:0] != 3'd6;
        end
        else if (o == 6'd26 || o == 6'd27) w = {3'b100, 1'(o - 6'd26), kr};
        else if (o == 6'd28) w = {3'b101, lr};
        else if (o >= 6'd29 && o <= 6'd32) w = {2'b11, 2'(o - 6'd29), kr};
        else if (o != 6'd0) ill = 1'b1;
    end
`ifdef ENC_VERIFY_EN
    localparam logic [1:0] LAST = VERIFY;
`else
    localparam logic [1:0] LAST = WRITE;
    logic unused_rdata;
    assign unused_rdata = ^pm_rdata;
    assign verify_err = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst || start) begin
            st <= IDLE;
            pm_addr <= rst ? '0 : base_addr;
            word_count <= '0;
            err_illegal <= 1'b0;
            wrapped <= 1'b0;
`ifdef ENC_VERIFY_EN
            verify_err <= 1'b0;
`endif
            if (rst) begin
                pm_wdata <= 12'h000;
                o <= '0;
                fr <= '0;
                dr <= 1'b0;
                br <= '0;
                kr <= '0;
                lr <= '0;
            end
        end else begin
            case (st)
                IDLE: if (in_valid) begin
                    o <= op_sel;
                    fr <= f;
                    dr <= d;
                    br <= bbb;
                    kr <= k;
                    lr <= longk;
                    st <= ENCODE;
                end
                ENCODE: begin
                    if (ill) err_illegal <= 1'b1;
                    else pm_wdata <= w;
                    st <= ill ? IDLE : WRITE;
                end
`ifdef ENC_VERIFY_EN
                WRITE: st <= VERIFY;
`endif
                LAST: begin
`ifdef ENC_VERIFY_EN
                    if (pm_rdata != pm_wdata) verify_err <= 1'b1;
`endif
                    pm_addr <= pm_addr + ADDR_W'(1);
                    word_count <= word_count + {{ADDR_W{1'b0}}, !word_count[ADDR_W]};
                    if (&pm_addr) wrapped <= 1'b1;
                    st <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/instr_encoder.md
# instr_encoder

Program-memory loader and instruction encoder for the 12-bit baseline MCU core. Accepts a mnemonic code plus operand fields on a valid/ready handshake, assembles the 12-bit instruction word that the core's instruction decoder recognises, and writes it into program memory at an auto-incrementing address. Sits between the debug/boot host interface and the program-memory write port. It is the writer for the core's instruction decoder.

## Interface
Parameters:
- ADDR_W, 9, program-memory address width (512 words); address wraps modulo 2^ADDR_W.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse: load base address, clear counters and flags.
- base_addr  in  ADDR_W  address loaded by start.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  encoder can accept; high only in IDLE.
- op_sel  in  6  mnemonic code 0..32 (list below); 33..63 illegal.
- f  in  5  file register field.
- d  in  1  destination bit.
- bbb  in  3  bit number.
- k  in  8  literal.
- longk  in  9  GOTO target.
- pm_we  out  1  program-memory write strobe, one cycle per word.
- pm_addr  out  ADDR_W  write/read address.
- pm_wdata  out  12  encoded instruction.
- pm_rdata  in  12  synchronous read data (used only with ENC_VERIFY_EN).
- word_count  out  ADDR_W+1  words written since start/reset.
- err_illegal  out  1  sticky: illegal op_sel or operand seen.
- wrapped  out  1  sticky: pm_addr wrapped 2^ADDR_W-1 -> 0.
- verify_err  out  1  sticky: readback mismatch.

## Operation
- Codes: 0 NOP 0x000; 1 MOVWF 0000_001f_ffff; 2 CLRW 0x040; 3 CLRF 0000_011f_ffff; 4..17 byte-oriented SUBWF, DECF, IORWF, ANDWF, XORWF, ADDWF, MOVF, COMF, INCF, DECFSZ, RRF, RLF, SWAPF, INCFSZ = {(op_sel-2) as 6 bits, d, f}; 18..21 BCF, BSF, BTFSC, BTFSS = {4'b0100+(op_sel-18), bbb, f}; 22 OPTION 0x002; 23 SLEEP 0x003; 24 CLRWDT 0x004; 25 TRIS = {9'b0, f[2:0]}, legal only for f[2:0] = 5 or 6; 26..27 RETLW, CALL = {4'b1000+(op_sel-26), k}; 28 GOTO {3'b101, longk}; 29..32 MOVLW, IORLW, ANDLW, XORLW = {4'b1100+(op_sel-29), k}.
- Unused operand fields are ignored.
- FSM: IDLE -> (in_valid & in_ready) capture fields -> ENCODE -> WRITE -> IDLE. With ENC_VERIFY_EN: WRITE -> VERIFY -> IDLE.
- ENCODE: build word into register; if illegal, set err_illegal, return to IDLE, no write, no address increment.
- WRITE: pm_we=1, pm_wdata valid, pm_addr current; on exit pm_addr+1, word_count+1; if pm_addr was 2^ADDR_W-1, next is 0 and wrapped set.
- start: in any state has priority: pm_addr<=base_addr, word_count, err_illegal, wrapped, verify_err <= 0, FSM -> IDLE; an in-flight word is dropped (no pm_we that cycle). in_valid ignored in the start cycle.
- word_count saturates at 2^ADDR_W.

## Timing
- Reset: FSM IDLE, in_ready=1, pm_we=0, pm_addr=0, pm_wdata=0, word_count=0, all flags 0.
- Accept in cycle N -> pm_we high in cycle N+2; in_ready low N+1..N+2, high N+3 (no verify). Throughput 1 word / 3 cycles.
- pm_wdata, pm_addr held stable from ENCODE exit until next accept.
- rst mid-operation: pending write aborted, all outputs to reset values next edge.

## Configuration
- ENC_VERIFY_EN defined: pm_addr held during WRITE and VERIFY; pm_rdata sampled at end of VERIFY (cycle N+3), compared to pm_wdata; mismatch sets verify_err; address increments on VERIFY exit; throughput 1 word / 4 cycles.
- Undefined: no VERIFY state, pm_rdata unused, verify_err tied 0.

## Test plan
- rst, start base 0x000; op 29 (MOVLW) k=0x5A -> pm_we at N+2, pm_addr 0x000, pm_wdata 0xC5A, word_count 1.
- Back-to-back: ADDWF f=0x07 d=1 -> 0x1E7 at 0x001; BSF bbb=3 f=0x03 -> 0x563 at 0x002; GOTO longk=0x1FF -> 0xBFF at 0x003.
- TRIS f=0x05 -> 0x005; TRIS f=0x07 and op_sel=40 -> no pm_we, err_illegal=1, pm_addr unchanged.
- start base 0x1FF, two NOPs -> writes at 0x1FF then 0x000, wrapped=1, word_count 2.
- start pulsed in ENCODE cycle -> no pm_we, pm_addr=base_addr, flags cleared; rst in WRITE-bound cycle -> all outputs reset.
- ENC_VERIFY_EN: memory model returns written data -> verify_err 0; forced pm_rdata 0xFFF against MOVLW 0x5A -> verify_err 1, throughput 4 cycles.
